// File: rtl/pwr_seq_ctrl.sv
// pwr_seq_ctrl: power-mode sequencer for one switchable domain (clock gate, isolation, retention, power switch)
// Ports:
//   clk, reset                 clock and asynchronous active-high reset
//   cfg_step_dly, cfg_tmo      per-step dwell and power-good timeout, both in cycles minus 1, captured at acceptance
//   mode_req, mode, mode_ack   four-phase mode request (mode 1 = on, 0 = off) and its acknowledge
//   pwr_good                   power-switch status
//   busy, err, pwr_state       sequencing status, sticky timeout flag, coarse state (00 ON, 01 moving, 10 OFF, 11 ERR)
//   clk_en, iso_en, ret_save, ret_restore, sw_disable   domain control outputs
module pwr_seq_ctrl #(
    parameter int DLY_W = 4,
    parameter int TMO_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DLY_W-1:0] cfg_step_dly,
    input  logic [TMO_W-1:0] cfg_tmo,
    input  logic             mode_req,
    input  logic             mode,
    input  logic             pwr_good,
    output logic             mode_ack,
    output logic             busy,
    output logic             err,
    output logic [1:0]       pwr_state,
    output logic             clk_en,
    output logic             iso_en,
    output logic             ret_save,
    output logic             ret_restore,
    output logic             sw_disable
);
    typedef enum logic [3:0] {
        S_ON, S_CLK_OFF, S_ISO_ON, S_SAVE, S_WAIT_OFF,
        S_OFF, S_WAIT_ON, S_RESTORE, S_ISO_REL, S_ERR
    } state_t;

    state_t           state, state_nx;
    logic [DLY_W-1:0] dly_q, dcnt, dcnt_nx;
    logic [TMO_W-1:0] tmo_q, tcnt, tcnt_nx;
    logic             pend, idle, idle_nx, accept;
    logic             clk_en_nx, iso_en_nx, ret_save_nx, ret_restore_nx, sw_disable_nx;
    logic [1:0]       pwr_state_nx;

    // pend marks a request that has been taken and whose mode_req has not yet
    // been seen low; it both blocks re-acceptance and qualifies the final ack.
    assign idle   = state inside {S_ON, S_OFF, S_ERR};
    assign accept = idle && mode_req && !mode_ack && !pend;

    always_comb begin
        state_nx = state;
        dcnt_nx  = (dcnt != '0) ? dcnt - DLY_W'(1) : dcnt;
        tcnt_nx  = (tcnt != '0) ? tcnt - TMO_W'(1) : tcnt;
        case (state)
            S_ON:       state_nx = (accept && !mode) ? S_CLK_OFF : S_ON;
            S_OFF:      state_nx = (accept && mode) ? S_WAIT_ON : S_OFF;
            S_ERR:      state_nx = (accept && mode) ? S_WAIT_ON : S_ERR;
            S_CLK_OFF:  state_nx = (dcnt == '0) ? S_ISO_ON : S_CLK_OFF;
            S_ISO_ON:   state_nx = (dcnt == '0) ? S_SAVE : S_ISO_ON;
            S_SAVE:     state_nx = (dcnt == '0) ? S_WAIT_OFF : S_SAVE;
            S_WAIT_OFF: state_nx = !pwr_good ? S_OFF : (tcnt == '0) ? S_ERR : S_WAIT_OFF;
            S_WAIT_ON:  state_nx = pwr_good ? S_RESTORE : (tcnt == '0) ? S_ERR : S_WAIT_ON;
            S_RESTORE:  state_nx = (dcnt == '0) ? S_ISO_REL : S_RESTORE;
            S_ISO_REL:  state_nx = (dcnt == '0) ? S_ON : S_ISO_REL;
            default:    state_nx = S_ON;
        endcase
        // Both counters reload on every state change; on the accepting edge the
        // captured copies are not yet valid, so the live config is used.
        if (state_nx != state) begin
            dcnt_nx = accept ? cfg_step_dly : dly_q;
            tcnt_nx = accept ? cfg_tmo : tmo_q;
        end
    end

    // Outputs are decoded from the next state and registered, so each output
    // flop changes together with the state it belongs to.
    always_comb begin
        idle_nx        = state_nx inside {S_ON, S_OFF, S_ERR};
        clk_en_nx      = state_nx == S_ON;
        iso_en_nx      = state_nx inside {S_ISO_ON, S_SAVE, S_WAIT_OFF, S_OFF, S_ERR, S_WAIT_ON, S_RESTORE};
        ret_save_nx    = state_nx == S_SAVE;
        ret_restore_nx = state_nx == S_RESTORE;
        sw_disable_nx  = state_nx inside {S_WAIT_OFF, S_OFF, S_ERR};
        pwr_state_nx   = (state_nx == S_ON)  ? 2'b00 :
                         (state_nx == S_OFF) ? 2'b10 :
                         (state_nx == S_ERR) ? 2'b11 : 2'b01;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_ON;
            dcnt        <= '0;
            tcnt        <= '0;
            dly_q       <= '0;
            tmo_q       <= '0;
            pend        <= 1'b0;
            mode_ack    <= 1'b0;
            err         <= 1'b0;
            busy        <= 1'b0;
            pwr_state   <= 2'b00;
            clk_en      <= 1'b1;
            iso_en      <= 1'b0;
            ret_save    <= 1'b0;
            ret_restore <= 1'b0;
            sw_disable  <= 1'b0;
        end else begin
            state       <= state_nx;
            dcnt        <= dcnt_nx;
            tcnt        <= tcnt_nx;
            if (accept) begin
                dly_q <= cfg_step_dly;
                tmo_q <= cfg_tmo;
            end
            pend        <= mode_req && (pend || accept);
            // Ack for a no-op acceptance, or at the end of a sequence whose
            // request was held throughout; held until mode_req is seen low.
            mode_ack    <= mode_req && (mode_ack || (accept && state_nx == state) || (pend && !idle && idle_nx));
            err         <= state_nx == S_ERR;
            busy        <= !idle_nx;
            pwr_state   <= pwr_state_nx;
            clk_en      <= clk_en_nx;
            iso_en      <= iso_en_nx;
            ret_save    <= ret_save_nx;
            ret_restore <= ret_restore_nx;
            sw_disable  <= sw_disable_nx;
        end
    end
endmodule

// File: doc/pwr_seq_ctrl.md
# pwr_seq_ctrl

Power-mode sequencer for one switchable power domain, such as a gated accumulator island. It accepts a four-phase mode request from the system and steps through clock gating, isolation, retention save and power-switch control in a fixed order. Each step has a programmable dwell time. It waits for the switch to report power-good before completing, with a timeout. It replaces hard-wired fixed-length power FSMs and sits between the system mode controller and the domain's clock gate, isolation cells, retention flops and power switch.

## Interface
Parameters:
- DLY_W, 4, width of the per-step dwell config
- TMO_W, 8, width of the power-good timeout config

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- cfg_step_dly  in  DLY_W  dwell per sequencing step, in cycles minus 1
- cfg_tmo  in  TMO_W  power-good wait limit, in cycles minus 1
- mode_req  in  1  four-phase request
- mode  in  1  target mode: 1 = domain on, 0 = domain off
- pwr_good  in  1  switch status: 1 = domain fully powered, 0 = fully off
- mode_ack  out  1  request complete, held while mode_req is high
- busy  out  1  sequence in progress
- err  out  1  sticky timeout flag
- pwr_state  out  2  00 = ON, 01 = transitioning, 10 = OFF, 11 = ERR
- clk_en  out  1  domain clock-gate enable
- iso_en  out  1  isolation enable
- ret_save  out  1  retention save strobe (level for dwell)
- ret_restore  out  1  retention restore strobe (level for dwell)
- sw_disable  out  1  power-switch off control

## Operation
- States: ON, CLK_OFF, ISO_ON, SAVE, WAIT_OFF, OFF, WAIT_ON, RESTORE, ISO_REL, ERR.
- All outputs are flop-driven Moore decodes of the state register, so there are no glitches.
- Outputs per state:
  - ON: clk_en=1, all others 0.
  - CLK_OFF: all 0.
  - ISO_ON: iso_en=1.
  - SAVE: iso_en=1, ret_save=1.
  - WAIT_OFF, OFF, ERR: iso_en=1, sw_disable=1.
  - WAIT_ON: iso_en=1.
  - RESTORE: iso_en=1, ret_restore=1.
  - ISO_REL: all 0.
- Acceptance:
  - A request is accepted in ON, OFF or ERR when mode_req=1 and mode_ack=0.
  - mode is sampled at acceptance; later changes to mode are ignored until the next request.
  - cfg_step_dly and cfg_tmo are captured at acceptance.
- Power-down (accepted in ON with mode=0): CLK_OFF → ISO_ON → SAVE → WAIT_OFF → OFF.
- Power-up (accepted in OFF or ERR with mode=1): WAIT_ON → RESTORE → ISO_REL → ON.
- Dwell:
  - CLK_OFF, ISO_ON, SAVE, RESTORE and ISO_REL each last exactly D = cfg_step_dly+1 cycles.
  - D is counted by one down-counter that reloads on every state entry.
- Wait states:
  - WAIT_OFF exits when pwr_good=0 is sampled.
  - WAIT_ON exits when pwr_good=1 is sampled.
  - If the condition is not met within T = cfg_tmo+1 cycles of entry, the block goes to ERR and sets err=1.
  - A condition met on the final cycle counts as success, not timeout.
- No-op requests:
  - mode=1 in ON, or mode=0 in OFF, gives no sequencing; mode_ack rises the next cycle.
  - mode=0 in ERR is also a no-op. It acks and stays in ERR with err=1.
- Ack and handshake:
  - On reaching ON, OFF or ERR at the end of a sequence, mode_ack=1.
  - mode_ack stays 1 until mode_req=0 is sampled, then drops the next cycle.
  - If mode_req drops mid-sequence, the sequence still completes and mode_ack is not raised.
- err clears when a power-up is accepted from ERR.
- busy=1 in every state except ON, OFF and ERR.

## Timing
- Reset state: ON.
- Reset output values: clk_en=1, iso_en=0, ret_save=0, ret_restore=0, sw_disable=0, mode_ack=0, busy=0, err=0, pwr_state=00.
- Reset is asynchronous and may be asserted mid-sequence. It forces ON immediately and turns the switch back on. The system holds reset until pwr_good=1.
- Power-down timeline, request sampled at cycle 0:
  - CLK_OFF from cycle 1
  - ISO_ON from 1+D
  - SAVE from 1+2D
  - WAIT_OFF from 1+3D
  - pwr_good=0 sampled at cycle 1+3D+k (k ≥ 0): OFF and mode_ack=1 at 2+3D+k
- Power-up timeline, request sampled at cycle 0:
  - WAIT_ON from cycle 1
  - pwr_good=1 sampled at 1+k: RESTORE from 2+k
  - ISO_REL from 2+k+D
  - ON and mode_ack=1 at 2+k+2D
- Timeout: with the wait entered at cycle E and pwr_good never matching, ERR and err=1 appear at E+T.
- Counters: the dwell counter is DLY_W bits and the timeout counter is TMO_W bits, both decrementing to 0 with no wrap. Maximum dwell is 2^DLY_W cycles.
- mode_req=1 held during busy is not a new request. The next request requires mode_req to be low for at least one cycle after mode_ack.

## Test plan
- **Reset values.** Assert reset mid-SAVE → all outputs at their reset values in the same cycle (asynchronous) and state ON; release reset with pwr_good=1 → no activity.
- **Power-down.** cfg_step_dly=2, mode=0 request, pwr_good falls 3 cycles after sw_disable → CLK_OFF/ISO_ON/SAVE dwell 3 cycles each and mode_ack=1 at cycle 14. Drop mode_req → mode_ack=0 at the next cycle.
- **Power-up.** cfg_step_dly=0, mode=1 from OFF, pwr_good rises after 5 cycles → RESTORE 1 cycle, ISO_REL 1 cycle, clk_en=1 with mode_ack at cycle 8.
- **Timeout.** cfg_tmo=3, pwr_good stuck at 1 in WAIT_OFF → ERR with err=1 exactly 4 cycles after entry. A following mode=1 request with pwr_good=1 recovers to ON and clears err.
- **No-op.** mode=1 request in ON → mode_ack the next cycle and no output change. mode toggled mid-sequence → ignored.
- **Dropped request.** mode_req deasserted during ISO_ON → sequence reaches OFF with mode_ack held at 0; the next request is accepted normally.
